// File: rtl/hdmi_fw_pkg.sv
// Shared definitions for the HDMI capture frame writer: FSM encoding and sizing helpers.
package hdmi_fw_pkg;

  typedef enum logic [7:0] {
    ST_IDLE      = 8'b0000_0001,
    ST_WAIT_DATA = 8'b0000_0010,
    ST_REQ       = 8'b0000_0100,
    ST_DATA      = 8'b0000_1000,
    ST_WAIT_DONE = 8'b0001_0000,
    ST_ADV       = 8'b0010_0000,
    ST_FRAME_END = 8'b0100_0000,
    ST_ABORT     = 8'b1000_0000
  } fw_state_e;

  localparam int BITS_PER_BYTE = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beat_bytes(input int data_w);
    return data_w / BITS_PER_BYTE;
  endfunction

endpackage

// File: rtl/hdmi_fw_buf_sel.sv
// Next frame-buffer index in the ring, stepping over the buffer the display is reading.
module hdmi_fw_buf_sel import hdmi_fw_pkg::*; #(
  parameter int NUM_FRAMES = 3,
  parameter int IDX_W      = idx_w(NUM_FRAMES)
) (
  input  logic [IDX_W-1:0] cur,
  input  logic [IDX_W-1:0] rd_buf,
  output logic [IDX_W-1:0] nxt
);

  localparam logic [IDX_W:0] NF = (IDX_W+1)'(NUM_FRAMES);

  logic [IDX_W:0] p1, p2;

  // Conditional subtract instead of modulo keeps this a pair of small adders.
  always_comb begin
    p1 = {1'b0, cur} + (IDX_W+1)'(1);
    if (p1 >= NF) p1 = p1 - NF;
    p2 = p1 + (IDX_W+1)'(1);
    if (p2 >= NF) p2 = p2 - NF;
    nxt = (p1[IDX_W-1:0] == rd_buf) ? p2[IDX_W-1:0] : p1[IDX_W-1:0];
  end

endmodule

// File: rtl/hdmi_frame_writer.sv
// DDR write engine: drains pixel beats from the CDC FIFO into a ring of frame buffers.
// Optional HDMI_FW_STATS_EN adds drop_cnt / burst_cnt statistics ports.
module hdmi_frame_writer import hdmi_fw_pkg::*; #(
  parameter int               ADDR_W       = 28,
  parameter int               DATA_W       = 256,
  parameter int               BURST_LEN    = 8,
  parameter int               FRAME_BEATS  = 12288,
  parameter int               NUM_FRAMES   = 3,
  parameter logic [ADDR_W-1:0] FB_BASE      = '0,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'('h0040_0000),
  parameter int               FIFO_DEPTH   = 512,
  parameter int               LVL_W        = $clog2(FIFO_DEPTH) + 1,
  parameter int               IDX_W        = idx_w(NUM_FRAMES)
) (
  input  logic              ddr_clk,
  input  logic              rstn,
  input  logic              init_done,
  input  logic              frame_start,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic [LVL_W-1:0]  fifo_level,
  output logic              fifo_rd_en,
  output logic              wr_req,
  input  logic              wr_ack,
  output logic [3:0]        awlen,
  output logic [ADDR_W-1:0] ddr_waddr,
  input  logic              wr_data_req,
  output logic [DATA_W-1:0] ddr_wdata,
  input  logic              wr_done,
  input  logic [IDX_W-1:0]  rd_buf,
  output logic [IDX_W-1:0]  done_buf,
  output logic              frame_done,
  output logic              frame_err
`ifdef HDMI_FW_STATS_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic [31:0]       burst_cnt
`endif
);

  localparam int BC_W = $clog2(FRAME_BEATS + 1);
  localparam int BB_W = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * beat_bytes(DATA_W));
  localparam logic [BC_W-1:0]   FRAME_LAST  = BC_W'(FRAME_BEATS - BURST_LEN);
  localparam logic [BB_W-1:0]   BEAT_LAST   = BB_W'(BURST_LEN - 1);

  fw_state_e        state;
  logic [IDX_W-1:0] wr_buf, nxt_buf;
  logic [BC_W-1:0]  beat_cnt;
  logic [BB_W-1:0]  bcnt;
  logic             resync;
  logic             start_now;

  function automatic logic [ADDR_W-1:0] base_of(input logic [IDX_W-1:0] idx);
    return FB_BASE + FRAME_STRIDE * ADDR_W'(idx);
  endfunction

  hdmi_fw_buf_sel #(.NUM_FRAMES(NUM_FRAMES), .IDX_W(IDX_W)) u_buf_sel (
    .cur    (wr_buf),
    .rd_buf (rd_buf),
    .nxt    (nxt_buf)
  );

  assign awlen      = 4'(BURST_LEN - 1);
  assign fifo_rd_en = (state == ST_DATA) && wr_data_req;
  assign ddr_wdata  = (state == ST_DATA) ? fifo_rdata : '0;
  // A start seen this very cycle counts as pending, so no pulse is lost at a state boundary.
  assign start_now  = frame_start || resync;

  always_ff @(posedge ddr_clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      wr_req     <= 1'b0;
      ddr_waddr  <= FB_BASE;
      done_buf   <= '0;
      wr_buf     <= IDX_W'(1);
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      beat_cnt   <= '0;
      bcnt       <= '0;
      resync     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (frame_start && state != ST_IDLE) resync <= 1'b1;
      case (state)
        ST_IDLE: if (init_done && start_now) begin
          ddr_waddr <= base_of(wr_buf);
          beat_cnt  <= '0;
          resync    <= 1'b0;
          state     <= ST_WAIT_DATA;
        end
        ST_WAIT_DATA:
          if (!init_done) state <= ST_IDLE;
          else if (fifo_level >= LVL_W'(BURST_LEN)) begin
            wr_req <= 1'b1;
            state  <= ST_REQ;
          end
        ST_REQ: if (wr_ack) begin
          wr_req <= 1'b0;
          bcnt   <= '0;
          state  <= ST_DATA;
        end
        ST_DATA: if (wr_data_req) begin
          bcnt <= bcnt + BB_W'(1);
          if (bcnt == BEAT_LAST) state <= wr_done ? ST_ADV : ST_WAIT_DONE;
        end
        ST_WAIT_DONE: if (wr_done) state <= ST_ADV;
        ST_ADV: begin
          ddr_waddr <= ddr_waddr + BURST_BYTES;
          beat_cnt  <= beat_cnt + BC_W'(BURST_LEN);
          if (beat_cnt == FRAME_LAST) begin
            done_buf   <= wr_buf;
            frame_done <= 1'b1;
            state      <= ST_FRAME_END;
          end else if (start_now) begin
            frame_err <= 1'b1;
            state     <= ST_ABORT;
          end else if (!init_done) state <= ST_IDLE;
          else state <= ST_WAIT_DATA;
        end
        ST_FRAME_END: begin
          wr_buf <= nxt_buf;
          if (init_done && start_now) begin
            ddr_waddr <= base_of(nxt_buf);
            beat_cnt  <= '0;
            resync    <= 1'b0;
            state     <= ST_WAIT_DATA;
          end else state <= ST_IDLE;
        end
        ST_ABORT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef HDMI_FW_STATS_EN
  always_ff @(posedge ddr_clk) begin
    if (!rstn) begin
      drop_cnt  <= '0;
      burst_cnt <= '0;
    end else begin
      if (state == ST_ABORT) drop_cnt <= drop_cnt + 16'd1;
      if (state == ST_ADV) burst_cnt <= burst_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hdmi_frame_writer.sv
// Scoreboard bench for hdmi_frame_writer: directed frames, resync abort, coincident done, reset.
// Define HDMI_FW_STATS_EN to also check the statistics counters.
module tb_hdmi_frame_writer;

  localparam logic [27:0] FB  = 28'h100_0000;
  localparam logic [27:0] B0  = 28'h100_0000;
  localparam logic [27:0] B1  = 28'h140_0000;

  logic         ddr_clk = 1'b0;
  logic         rstn, init_done, frame_start;
  logic [255:0] fifo_rdata;
  logic [9:0]   fifo_level;
  logic         fifo_rd_en, wr_req, wr_ack, wr_data_req, wr_done;
  logic [3:0]   awlen;
  logic [27:0]  ddr_waddr;
  logic [255:0] ddr_wdata;
  logic [1:0]   rd_buf, done_buf;
  logic         frame_done, frame_err;
`ifdef HDMI_FW_STATS_EN
  logic [15:0]  drop_cnt;
  logic [31:0]  burst_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] head = 32'h1000;
  int pops = 0;
  logic [27:0] exp_addr[$];
  logic [1:0]  exp_done[$];
  int exp_err_n = 0;
  int lat;

  assign fifo_rdata = {8{head}};

  hdmi_frame_writer #(
    .ADDR_W(28), .DATA_W(256), .BURST_LEN(8), .FRAME_BEATS(16), .NUM_FRAMES(3),
    .FB_BASE(FB), .FRAME_STRIDE(28'h040_0000), .FIFO_DEPTH(512)
  ) dut (
    .ddr_clk(ddr_clk), .rstn(rstn), .init_done(init_done), .frame_start(frame_start),
    .fifo_rdata(fifo_rdata), .fifo_level(fifo_level), .fifo_rd_en(fifo_rd_en),
    .wr_req(wr_req), .wr_ack(wr_ack), .awlen(awlen), .ddr_waddr(ddr_waddr),
    .wr_data_req(wr_data_req), .ddr_wdata(ddr_wdata), .wr_done(wr_done),
    .rd_buf(rd_buf), .done_buf(done_buf), .frame_done(frame_done), .frame_err(frame_err)
`ifdef HDMI_FW_STATS_EN
    , .drop_cnt(drop_cnt), .burst_cnt(burst_cnt)
`endif
  );

  always #5 ddr_clk = ~ddr_clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ddr_clk);
    #1;
  endtask

  // FIFO model: head advances on every pop.
  always @(posedge ddr_clk) if (fifo_rd_en) begin
    head <= head + 1;
    pops <= pops + 1;
  end

  // Monitor: compares DUT output events against the expected queues.
  always @(negedge ddr_clk) if (rstn) begin
    if (wr_req && wr_ack) begin
      chk("wdata_outside_data", ddr_wdata, 256'd0);
      if (exp_addr.size() == 0) begin
        total++; bad++;
        $display("FAIL burst_addr: unexpected burst at %0h", ddr_waddr);
      end else chk("burst_addr", ddr_waddr, exp_addr.pop_front());
    end
    if (fifo_rd_en) chk("wdata", ddr_wdata, {8{head}});
    if (frame_done) begin
      if (exp_done.size() == 0) begin
        total++; bad++;
        $display("FAIL frame_done: unexpected pulse, done_buf=%0d", done_buf);
      end else chk("done_buf", done_buf, exp_done.pop_front());
    end
    if (frame_err) begin
      total++;
      if (exp_err_n == 0) begin
        bad++;
        $display("FAIL frame_err: unexpected pulse");
      end else exp_err_n--;
    end
  end

  // DDR controller model for one burst; lat = cycles waited for wr_req.
  task automatic burst(input int extra, input bit coincide, input int fs_at, output int lat_o);
    int p0;
    lat_o = 0;
    while (!wr_req && lat_o < 60) begin tick(); lat_o++; end
    if (!wr_req) begin
      total++; bad++;
      $display("FAIL wr_req_timeout: got 0 want 1");
      lat_o = -1;
      return;
    end
    p0 = pops;
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    for (int i = 0; i < 8 + extra; i++) begin
      wr_data_req = 1'b1;
      wr_done     = coincide && (i == 7);
      frame_start = (i == fs_at);
      tick();
      wr_done = 1'b0; frame_start = 1'b0;
    end
    wr_data_req = 1'b0;
    chk("burst_pops", 256'(pops - p0), 256'd8);
    if (!coincide) begin wr_done = 1'b1; tick(); wr_done = 1'b0; end
  endtask

  task automatic pulse_start();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && exp_done.size() > 0; k++) tick();
    chk("frame_done_seen", 256'(exp_done.size()), 256'd0);
  endtask

  initial begin
    rstn = 0; init_done = 0; frame_start = 0; wr_ack = 0; wr_data_req = 0; wr_done = 0;
    rd_buf = 2'd2; fifo_level = 10'd8;
    repeat (3) tick();
    chk("rst_wr_req", wr_req, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_waddr", ddr_waddr, FB);
    chk("rst_wdata", ddr_wdata, 0);
    chk("rst_done_buf", done_buf, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_awlen", awlen, 4'd7);
    rstn = 1; tick();

    // Frame 1 into buffer 1; buffer 2 is being displayed so the next one is 0.
    init_done = 1;
    exp_addr.push_back(B1); exp_addr.push_back(B1 + 28'd256); exp_done.push_back(2'd1);
    pulse_start();
    burst(0, 0, -1, lat); chk("start_latency", 256'(lat), 256'd1);
    burst(0, 0, -1, lat); chk("turnaround", 256'(lat), 256'd2);
    drain();

    // Frame 2 into buffer 0, FIFO one beat short at first.
    exp_addr.push_back(B0); exp_addr.push_back(B0 + 28'd256); exp_done.push_back(2'd0);
    fifo_level = 10'd7;
    pulse_start();
    repeat (5) tick();
    chk("wr_req_low_lvl7", wr_req, 0);
    fifo_level = 10'd8;
    burst(0, 0, -1, lat); chk("level_latency", 256'(lat), 256'd1);
    burst(0, 0, -1, lat);
    drain();

    // Frame 3 into buffer 1, resync mid-burst aborts and restarts at the same base.
    exp_addr.push_back(B1); exp_addr.push_back(B1); exp_addr.push_back(B1 + 28'd256);
    exp_done.push_back(2'd1); exp_err_n = 1;
    pulse_start();
    burst(0, 0, 3, lat);
    burst(0, 0, -1, lat);
    burst(0, 0, -1, lat);
    drain();
    chk("frame_err_seen", 256'(exp_err_n), 256'd0);

    // Frame 4 into buffer 0, wr_done with the last beat plus two stray beat requests.
    exp_addr.push_back(B0); exp_addr.push_back(B0 + 28'd256); exp_done.push_back(2'd0);
    pulse_start();
    burst(2, 1, -1, lat);
    burst(0, 0, -1, lat); chk("direct_adv", 256'(lat), 256'd0);
    drain();

`ifdef HDMI_FW_STATS_EN
    chk("drop_cnt", drop_cnt, 16'd1);
    chk("burst_cnt", burst_cnt, 32'd9);
`endif

    // Reset in the middle of a burst into buffer 1.
    exp_addr.push_back(B1);
    pulse_start();
    lat = 0;
    while (!wr_req && lat < 60) begin tick(); lat++; end
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    wr_data_req = 1'b1;
    repeat (3) tick();
    rstn = 0; tick();
    chk("mid_rst_wr_req", wr_req, 0);
    chk("mid_rst_rd_en", fifo_rd_en, 0);
    chk("mid_rst_wdata", ddr_wdata, 0);
    chk("mid_rst_waddr", ddr_waddr, FB);
    chk("mid_rst_done_buf", done_buf, 0);
`ifdef HDMI_FW_STATS_EN
    chk("mid_rst_burst_cnt", burst_cnt, 32'd0);
`endif
    wr_data_req = 1'b0; rstn = 1; tick();

    chk("addr_queue_empty", 256'(exp_addr.size()), 256'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
